// File: rtl/gol_frame_reader_if.sv
// gol_frame_reader_if: valid/ready row stream carrying one grid row plus its index, live count and last flag
interface gol_frame_reader_if #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int RW     = $clog2(HEIGHT),
  parameter int CW     = $clog2(WIDTH + 1)
);
  logic            valid;
  logic            ready;
  logic [WIDTH-1:0] data;
  logic [RW-1:0]   row;
  logic [CW-1:0]   live;
  logic            last;
  modport master (output valid, data, row, live, last, input ready);
  modport slave  (input valid, data, row, live, last, output ready);
endinterface

// File: rtl/gol_frame_reader.sv
// gol_frame_reader: snapshots the cell-state vector on start and streams it row by row
// with per-row live counts, then reports the frame total.
module gol_frame_reader #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int RW     = $clog2(HEIGHT),
  parameter int CW     = $clog2(WIDTH + 1),
  parameter int FW     = $clog2(WIDTH * HEIGHT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH*HEIGHT-1:0]   i_grid_state,
  input  logic                      i_start,
  gol_frame_reader_if.master        o_out,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [FW-1:0]             o_frame_live
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t                    r_state;
  logic                      r_valid;
  logic                      r_done;
  logic [WIDTH*HEIGHT-1:0]   r_snap;
  logic [RW-1:0]             r_row;
  logic [FW-1:0]             r_acc;
  logic [FW-1:0]             r_frame_live;
  logic [WIDTH-1:0]          w_data;
  logic [CW-1:0]             w_live;
  logic                      w_last;
  logic                      w_accept;
  assign w_data   = r_snap[r_row*WIDTH +: WIDTH];
  assign w_last   = r_row == RW'(HEIGHT - 1);
  assign w_accept = r_valid & o_out.ready;
  always_comb begin
    w_live = '0;
    for (int i = 0; i < WIDTH; i++) w_live = w_live + CW'(w_data[i]);
  end
  // Beat fields are gated by valid so the bus reads all-zero whenever idle or in reset.
  assign o_out.valid  = r_valid;
  assign o_out.data   = r_valid ? w_data : '0;
  assign o_out.row    = r_valid ? r_row : '0;
  assign o_out.live   = r_valid ? w_live : '0;
  assign o_out.last   = r_valid & w_last;
  assign o_busy       = r_valid;
  assign o_done       = r_done;
  assign o_frame_live = r_frame_live;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_snap       <= '0;
      r_row        <= '0;
      r_acc        <= '0;
      r_frame_live <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_snap  <= i_grid_state;
          r_row   <= '0;
          r_acc   <= '0;
          r_valid <= 1'b1;
          r_state <= SEND;
        end
        SEND: if (w_accept) begin
          r_acc <= r_acc + FW'(w_live);
          if (w_last) begin
            r_frame_live <= r_acc + FW'(w_live);
            r_done       <= 1'b1;
            r_valid      <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_row <= r_row + RW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/gol_frame_reader.md
# gol_frame_reader

Reads out the Game of Life grid one row at a time. On `start` it takes a one-cycle snapshot of the flat cell-state vector driven by the grid of `gol_cell` instances. It then streams the snapshot row by row over a valid/ready interface, attaching a per-row live-cell count and a frame total. It sits between the cell array and the host/display side: the cells write state every generation, and this block is the reader of that state.

## Interface
Parameters:
- `WIDTH`, 8, cells per row (>= 2)
- `HEIGHT`, 8, rows per frame (>= 2)
- `RW`, $clog2(HEIGHT), row index width
- `CW`, $clog2(WIDTH+1), per-row live count width
- `FW`, $clog2(WIDTH*HEIGHT+1), frame live count width

Ports:
- `clk` in 1: single clock; all logic on posedge
- `rst` in 1: asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- `grid_state` in WIDTH*HEIGHT: cell states; bit `r*WIDTH+c` = cell (row r, column c)
- `start` in 1: request a frame snapshot and readout
- `out_ready` in 1: downstream accepts the current beat
- `out_valid` out 1: beat available
- `out_data` out WIDTH: snapshot row; bit c = column c
- `out_row` out RW: row index of current beat
- `out_live` out CW: number of 1s in `out_data`
- `out_last` out 1: current beat is row HEIGHT-1
- `busy` out 1: frame readout in progress
- `done` out 1: one-cycle pulse after last beat accepted
- `frame_live` out FW: total live cells of last completed frame

## Operation
- States: IDLE, SEND.
- IDLE:
  - `busy`=0 and `out_valid`=0.
  - `start`=1 at a posedge loads `snap <= grid_state`, clears the row counter to 0 and the accumulator to 0, and enters SEND.
- SEND:
  - `out_valid`=1 and `busy`=1.
  - `out_data` = `snap[row*WIDTH +: WIDTH]`, `out_row` = row, `out_live` = popcount(`out_data`), and `out_last` = (row == HEIGHT-1).
- Beat acceptance is `out_valid & out_ready`:
  - Each accepted beat adds `out_live` to the accumulator.
  - If not last, row increments.
  - If last, the next state is IDLE, `frame_live` <= accumulator + `out_live`, and `done` pulses.
- While `out_valid`=1 and `out_ready`=0, all `out_*` stay stable; the snapshot is never altered mid-frame.
- `start` while in SEND is ignored; there is no queuing.
- `grid_state` changes after the snapshot have no effect on the current frame.
- `frame_live` holds its value until the next frame completes. It is not cleared by `start`.
- Arithmetic:
  - Popcount is zero-extended to CW.
  - The accumulator is FW wide and cannot overflow, since its maximum is WIDTH*HEIGHT.
- The row counter never exceeds HEIGHT-1; there is no wrap inside a frame.

## Timing
- Reset (async assert, `rst`=0):
  - State goes to IDLE.
  - `snap`, row, the accumulator, `frame_live`, `done`, `busy` and `out_valid` all go to 0.
  - `out_data`, `out_row`, `out_live` and `out_last` read 0.
- Deassertion is synchronous to `clk` at the system level.
- Reset mid-frame aborts the frame immediately: no `done` pulse and no `frame_live` update.
- `start` sampled at edge N gives `out_valid`=1 with row 0 after edge N.
- With `out_ready` held high, one row is accepted per cycle, so HEIGHT beats take HEIGHT cycles.
- Last beat accepted at edge M:
  - After edge M, `out_valid`=0, `busy`=0, `done`=1, and `frame_live` is updated.
  - After edge M+1, `done`=0.
- `start` asserted during the `done` cycle is accepted, since the state is IDLE. This allows back-to-back frames with one idle cycle between them.
- `out_ready` may be high while `out_valid`=0; it has no effect.

## Test plan
- **Reset values:** WIDTH=4, HEIGHT=4.
  - Stimulus: assert `rst`=0 asynchronously mid-cycle.
  - Required: all outputs 0 immediately, with no wait for a clock edge.
- **Full frame, ready high:** `grid_state`=16'hF731, one-cycle `start`, `out_ready`=1.
  - Beats on 4 consecutive cycles with `out_data` = 1, 3, 7, F, `out_live` = 1, 2, 3, 4, and `out_last` only on row 3.
  - Then `done` for 1 cycle, `frame_live`=10, `busy`=0.
- **Backpressure:** same frame, with `out_ready` low for 3 cycles while row 1 is presented.
  - `out_data`=3, `out_row`=1 and `out_live`=2 held stable for 3 cycles.
  - Total frame still completes with `frame_live`=10.
- **Snapshot isolation:** change `grid_state` to 16'h0000 one cycle after `start`.
  - Streamed rows still 1, 3, 7, F.
  - `start` pulses during SEND are ignored: exactly 4 beats and one `done`.
- **Back-to-back:** assert `start` in the `done` cycle, with `grid_state`=16'hFFFF.
  - Second frame begins the next cycle; all rows are F and `frame_live`=16.
- **Reset mid-frame:** assert `rst`=0 after row 1 is accepted, then release it.
  - `frame_live` stays at its reset value 0, there is no `done` pulse, and the block is in IDLE.
  - A new `start` streams from row 0.
